// File: rtl/des_pkg.sv
// Shared DES definitions: widths, key-schedule tables, per-round shift amounts
// and the round-engine state encoding.
package des_pkg;

  localparam int HALF_W   = 32;
  localparam int KEY_W    = 64;
  localparam int CD_W     = 28;
  localparam int SUBKEY_W = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [1:CD_W*2] pc1(input logic [1:KEY_W] k);
    logic [1:CD_W*2] o;
    for (int i = 0; i < CD_W*2; i++) o[i+1] = k[PC1_T[i]];
    return o;
  endfunction

  function automatic logic [1:SUBKEY_W] pc2(input logic [1:CD_W*2] cd);
    logic [1:SUBKEY_W] o;
    for (int i = 0; i < SUBKEY_W; i++) o[i+1] = cd[PC2_T[i]];
    return o;
  endfunction

  // Decrypt walks the schedule backwards: no move on round 1, then right rotations.
  function automatic logic [1:0] shift_amt(input int rnd, input logic dec);
    logic [1:0] s;
    if (rnd < 1 || rnd > 16) s = 2'd0;
    else if (dec && rnd == 1) s = 2'd0;
    else s = SHIFTS[rnd-1];
    return s;
  endfunction

  function automatic logic [1:CD_W] rotl(input logic [1:CD_W] v, input logic [1:0] n);
    logic [1:CD_W] o;
    case (n)
      2'd1:    o = {v[2:CD_W], v[1]};
      2'd2:    o = {v[3:CD_W], v[1:2]};
      default: o = v;
    endcase
    return o;
  endfunction

  function automatic logic [1:CD_W] rotr(input logic [1:CD_W] v, input logic [1:0] n);
    logic [1:CD_W] o;
    case (n)
      2'd1:    o = {v[CD_W], v[1:CD_W-1]};
      2'd2:    o = {v[CD_W-1:CD_W], v[1:CD_W-2]};
      default: o = v;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/des_if.sv
// Block-in / preoutput-out handshake between IP, the round engine and FP.
interface des_if;
  import des_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [1:HALF_W]     left_in;
  logic [1:HALF_W]     right_in;
  logic [1:KEY_W]      key;
  logic                decrypt;
  logic                out_valid;
  logic                out_ready;
  logic [1:HALF_W]     left_out;
  logic [1:HALF_W]     right_out;

  modport master (
    output in_valid, left_in, right_in, key, decrypt, out_ready,
    input  in_ready, out_valid, left_out, right_out
  );

  modport slave (
    input  in_valid, left_in, right_in, key, decrypt, out_ready,
    output in_ready, out_valid, left_out, right_out
  );
endinterface

// File: rtl/des_round_engine_f.sv
// DES round function f(R, K): E expansion, subkey mix, S1-S8, P permutation.
module des_f_function
  import des_pkg::*;
(
  input  logic [1:HALF_W]   r,
  input  logic [1:SUBKEY_W] k,
  output logic [1:HALF_W]   f
);

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each box packs its 64 entries row-major, entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
  };

  logic [1:SUBKEY_W] x_s;
  logic [1:HALF_W]   s_s;

  // Outer bits select the row, inner four bits the column.
  function automatic logic [3:0] sbox(input int j, input logic [1:6] b);
    logic [5:0] ix;
    ix = {b[1], b[6], b[2:5]};
    return SBOX[j][4*(63-int'(ix)) +: 4];
  endfunction

  // Expand, mix with the subkey, substitute and permute.
  always_comb begin
    x_s = '0;
    s_s = '0;
    f   = '0;
    for (int i = 0; i < SUBKEY_W; i++) x_s[i+1] = r[E_T[i]] ^ k[i+1];
    for (int j = 0; j < 8; j++) s_s[4*j+1 +: 4] = sbox(j, x_s[6*j+1 +: 6]);
    for (int i = 0; i < HALF_W; i++) f[i+1] = s_s[P_T[i]];
  end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES Feistel core: one round per clock with an on-the-fly key
// schedule, handing the swapped preoutput (R16, L16) on to FP.
module des_round_engine
  import des_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input logic clk,
  input logic rst_n,
  des_if.slave bus
);

  localparam int RW = $clog2(ROUNDS + 1);

  state_t            state_r, state_s;
  logic [1:0]        rst_sync_r;
  logic              rst_int_n;
  logic [1:HALF_W]   l_r, r_r, f_s, left_out_r, right_out_r;
  logic [1:CD_W]     c_r, d_r, c_s, d_s;
  logic [1:SUBKEY_W] k_s;
  logic [RW-1:0]     round_r;
  logic              dec_r, out_valid_r, in_ready_s, last_s;
  logic [1:0]        sh_s;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_r <= 2'b00;
    else        rst_sync_r <= {rst_sync_r[0], 1'b1};
  end
  assign rst_int_n = rst_sync_r[1];

  // State register.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state_r <= IDLE;
    else            state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.in_valid) state_s = RUN;  else state_s = IDLE;
      RUN:     if (last_s)       state_s = DONE; else state_s = RUN;
      DONE:    if (bus.out_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready_s = 1'b0;
    if (state_r == IDLE) in_ready_s = 1'b1;
    else                 in_ready_s = 1'b0;
  end

  // Subkey for the current round, from the rotated C/D halves.
  always_comb begin
    last_s = (round_r == RW'(ROUNDS));
    sh_s   = shift_amt(int'(round_r), dec_r);
    c_s    = c_r;
    d_s    = d_r;
    if (dec_r) begin
      c_s = rotr(c_r, sh_s);
      d_s = rotr(d_r, sh_s);
    end else begin
      c_s = rotl(c_r, sh_s);
      d_s = rotl(d_r, sh_s);
    end
    k_s = pc2({c_s, d_s});
  end

  des_f_function u_f (
    .r (r_r),
    .k (k_s),
    .f (f_s)
  );

  // Block capture, Feistel rounds and the registered preoutput.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      l_r         <= '0;
      r_r         <= '0;
      c_r         <= '0;
      d_r         <= '0;
      round_r     <= '0;
      dec_r       <= 1'b0;
      out_valid_r <= 1'b0;
      left_out_r  <= '0;
      right_out_r <= '0;
    end else begin
      case (state_r)
        IDLE: if (bus.in_valid) begin
          l_r        <= bus.left_in;
          r_r        <= bus.right_in;
          {c_r, d_r} <= pc1(bus.key);
          dec_r      <= bus.decrypt;
          round_r    <= RW'(1);
        end
        RUN: begin
          l_r     <= r_r;
          r_r     <= l_r ^ f_s;
          c_r     <= c_s;
          d_r     <= d_s;
          round_r <= round_r + RW'(1);
          if (last_s) begin
            left_out_r  <= l_r ^ f_s;
            right_out_r <= r_r;
            out_valid_r <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) out_valid_r <= 1'b0;
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.left_out  = left_out_r;
  assign bus.right_out = right_out_r;

endmodule
